sfx_mixer: RTL

Multi-voice sound-effect mixer feeding `audio_codec`. It is the generalised successor of the single-voice `gunshot_player`. It plays up to `N_CH` independently triggered samples from one shared sample ROM, sums them with saturation, and pushes one mixed sample per codec request. Game events such as `shot`, `killed` and start map to individual trigger lines in the top level.

---
 rtl/sfx_mixer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sfx_mixer.sv
// sfx_mixer: multi-voice sound-effect mixer in front of audio_codec.
//
// Plays up to N_CH independently triggered samples out of one shared sample
// ROM, sums them with saturation and hands one mixed sample to the codec per
// codec request.
//
// Each frame starts in IDLE when the codec reports write_ready.
// The frame then walks every voice through a FETCH/ACC slot pair:
// the slot is taken even when the voice is silent, so frame length is fixed.
// After the last voice it clamps the sum (SAT) and writes it (WRITE).
//
// Optional feature: define SFX_MIXER_ATTEN_EN to enable per-voice attenuation.
// Each ROM sample is then arithmetically shifted right by ch_atten[2*i +: 2]
// before it is accumulated. Without the macro ch_atten is ignored.
//
// Handshake: the ROM is a fixed-latency slave. rom_data must be valid exactly
// one cycle after a cycle with rom_rd=1. The codec side is valid/ready-like:
// aud_write is high only in a cycle where aud_write_ready is high, and it
// stays high for exactly that one cycle. aud_write_d is stable from SAT until
// the pulse has been taken.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   trig[N_CH]           one-cycle start/retrigger pulse per voice
//   ch_base, ch_len      per-voice ROM start address / length (quasi-static)
//   ch_atten             per-voice 2-bit right-shift attenuation
//   rom_rd, rom_addr     ROM read strobe and address
//   rom_data             ROM read data (1-cycle latency)
//   aud_write_ready      codec write_ready
//   aud_write            codec write strobe
//   aud_write_d          mixed, saturated sample
//   active[N_CH]         voice i currently playing
//   fsm_state            current controller state (debug observation)
module sfx_mixer #(
    parameter int N_CH     = 4,
    parameter int SAMPLE_W = 24,
    parameter int ADDR_W   = 14
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_CH-1:0]          trig,
    input  logic [N_CH*ADDR_W-1:0]   ch_base,
    input  logic [N_CH*ADDR_W-1:0]   ch_len,
    input  logic [2*N_CH-1:0]        ch_atten,
    output logic                     rom_rd,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [SAMPLE_W-1:0]      rom_data,
    input  logic                     aud_write_ready,
    output logic                     aud_write,
    output logic [SAMPLE_W-1:0]      aud_write_d,
    output logic [N_CH-1:0]          active,
    output logic [2:0]               fsm_state
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    // One extra bit per doubling of voices, so the raw sum can never wrap.
    localparam int ACC_W = SAMPLE_W + $clog2(N_CH);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ACC   = 3'd2,
        S_SAT   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                    state;
    logic [CH_W-1:0]           ch;
    logic [CH_W-1:0]           nxt_ch;
    logic [N_CH-1:0]           pend;
    logic [ADDR_W-1:0]         pos [N_CH];
    logic signed [ACC_W-1:0]   acc;

    logic [ADDR_W-1:0]         base_a [N_CH];
    logic [ADDR_W-1:0]         len_a  [N_CH];
    logic [N_CH-1:0]           len_nz;
    logic [N_CH-1:0]           start;
    logic [ADDR_W-1:0]         first_pos;
    logic signed [SAMPLE_W-1:0] voice_sample;
    logic signed [ACC_W-1:0]   voice_ext;
    logic [SAMPLE_W-1:0]       sat_value;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_unpack
            assign base_a[g] = ch_base[g*ADDR_W +: ADDR_W];
            assign len_a[g]  = ch_len[g*ADDR_W +: ADDR_W];
            assign len_nz[g] = |ch_len[g*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Pending triggers on zero-length voices are dropped rather than started.
    assign start     = pend & len_nz;
    assign first_pos = start[0] ? '0 : pos[0];
    assign nxt_ch    = ch + CH_W'(1);

`ifdef SFX_MIXER_ATTEN_EN
    always_comb begin
        voice_sample = $signed(rom_data) >>> ch_atten[2*ch +: 2];
    end
`else
    logic unused_atten;
    assign unused_atten = ^ch_atten;
    always_comb begin
        voice_sample = $signed(rom_data);
    end
`endif

    assign voice_ext = ACC_W'(voice_sample);

    always_comb begin
        sat_value = acc[SAMPLE_W-1:0];
        if (acc > SAT_MAX) begin
            sat_value = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            sat_value = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
    end

    // The strobe is qualified by the live ready, so a pulse can never be
    // emitted into a codec that has just dropped write_ready.
    assign aud_write = (state == S_WRITE) && aud_write_ready;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            ch          <= '0;
            pend        <= '0;
            acc         <= '0;
            active      <= '0;
            rom_rd      <= 1'b0;
            rom_addr    <= '0;
            aud_write_d <= '0;
            for (int i = 0; i < N_CH; i++) begin
                pos[i] <= '0;
            end
        end else begin
            rom_rd <= 1'b0;
            // Triggers latch in any state. All pending triggers are consumed
            // at frame start; a trigger in that same cycle waits a frame.
            if ((state == S_IDLE) && aud_write_ready) begin
                pend <= trig;
            end else begin
                pend <= pend | trig;
            end

            case (state)
                S_IDLE: begin
                    if (aud_write_ready) begin
                        acc <= '0;
                        ch  <= '0;
                        for (int i = 0; i < N_CH; i++) begin
                            if (start[i]) begin
                                active[i] <= 1'b1;
                                pos[i]    <= '0;
                            end
                        end
                        // The read for voice 0 is registered here so that it
                        // is presented during the FETCH cycle itself.
                        rom_rd   <= start[0] | active[0];
                        rom_addr <= base_a[0] + first_pos;
                        state    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    state <= S_ACC;
                end

                S_ACC: begin
                    if (active[ch]) begin
                        acc <= acc + voice_ext;
                        if (pos[ch] == len_a[ch] - ADDR_W'(1)) begin
                            active[ch] <= 1'b0;
                        end else begin
                            pos[ch] <= pos[ch] + ADDR_W'(1);
                        end
                    end
                    if (ch == CH_W'(N_CH-1)) begin
                        state <= S_SAT;
                    end else begin
                        ch       <= nxt_ch;
                        rom_rd   <= active[nxt_ch];
                        rom_addr <= base_a[nxt_ch] + pos[nxt_ch];
                        state    <= S_FETCH;
                    end
                end

                S_SAT: begin
                    aud_write_d <= sat_value;
                    state       <= S_WRITE;
                end

                S_WRITE: begin
                    if (aud_write_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
